// File: rtl/axi_lite_slave.sv
// AXI4-Lite register bank responder.
// Terminates AXI4-Lite transactions into NUM_REGS read/write registers with
// byte-strobe support, SLVERR for addresses outside the bank, and exposes the
// live register contents plus a per-register write-commit pulse.
module axi_lite_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  // write response channel
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  // read data channel
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  // register bank view
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(NUM_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} r_state_t;

  // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned compare
  // covers both bounds (the bank is aligned and cannot wrap the address space).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE_ADDR) < BANK_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
  endfunction

  w_state_t              w_state, w_state_nxt;
  r_state_t              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_accept, w_commit, ar_accept;
  logic                  w_hit, r_hit;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign aw_accept = AWREADY & AWVALID;
  assign w_commit  = WREADY & WVALID;
  assign ar_accept = ARREADY & ARVALID;
  assign w_hit     = in_range(aw_addr);
  assign w_idx     = reg_index(aw_addr);
  assign r_hit     = in_range(ARADDR);
  assign r_idx     = reg_index(ARADDR);

  // State registers for both channel FSMs; reset parks them in idle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Write FSM next state and handshake outputs, decoded purely from state.
  always_comb begin
    w_state_nxt = W_IDLE;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY     = 1'b1;
        w_state_nxt = AWVALID ? W_DATA : W_IDLE;
      end
      W_DATA: begin
        WREADY      = 1'b1;
        w_state_nxt = WVALID ? W_RESP : W_DATA;
      end
      W_RESP: begin
        BVALID      = 1'b1;
        w_state_nxt = BREADY ? W_IDLE : W_RESP;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM next state and handshake outputs, decoded purely from state.
  always_comb begin
    r_state_nxt = R_IDLE;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY     = 1'b1;
        r_state_nxt = ARVALID ? R_DATA : R_IDLE;
      end
      R_DATA: begin
        RVALID      = 1'b1;
        r_state_nxt = RREADY ? R_IDLE : R_DATA;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write path: latch AW address, commit strobed bytes, set response and pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_addr  <= '0;
      bresp_q  <= RESP_OKAY;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_accept) aw_addr <= AWADDR;
      if (w_commit) begin
        if (w_hit) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (WSTRB[k]) regs[w_idx][k*8 +: 8] <= WDATA[k*8 +: 8];
          end
          wr_pulse[w_idx] <= 1'b1;
          bresp_q         <= RESP_OKAY;
        end else begin
          bresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  // Read path: capture data on AR accept; sees pre-write contents on a collision.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_accept) begin
      rdata_q <= r_hit ? regs[r_idx] : '0;
      rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign BRESP      = bresp_q;
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign wr_pulse_o = wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed testbench for axi_lite_slave (32-bit data, 16 registers, base 0).
// Expected responses are queued when a transaction is issued and popped when
// the DUT returns the matching response; a register model tracks contents.
module tb_axi_lite_slave;

  localparam int NR = 16;

  logic          ACLK    = 1'b0;
  logic          ARESETn = 1'b0;
  logic [31:0]   AWADDR  = '0;
  logic [2:0]    AWPROT  = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [31:0]   WDATA   = '0;
  logic [3:0]    WSTRB   = '0;
  logic          WVALID  = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY  = 1'b1;
  logic [31:0]   ARADDR  = '0;
  logic [2:0]    ARPROT  = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY  = 1'b1;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]    wr_pulse_o;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  rsp_t        wq[$];
  rsp_t        rq[$];
  logic [31:0] mdl [NR];
  int          exp_pulse [NR];
  int          pulse_cnt [NR];
  int          checks = 0;
  int          errors = 0;

  axi_lite_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("regs_o[%0d]", i), regs_o[i*32 +: 32], mdl[i]);
      check($sformatf("wr_pulse_cnt[%0d]", i), pulse_cnt[i], exp_pulse[i]);
    end
  endtask

  // Enters and leaves on a falling edge; hold = cycles BREADY is kept low.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int hold);
    rsp_t       e, got;
    logic [1:0] b0;
    e.data = '0;
    if (a < 32'h40) begin
      e.resp = 2'b00;
      for (int k = 0; k < 4; k++) if (s[k]) mdl[a[5:2]][k*8 +: 8] = d[k*8 +: 8];
      exp_pulse[a[5:2]]++;
    end else begin
      e.resp = 2'b10;
    end
    wq.push_back(e);
    BREADY  = (hold == 0);
    check("wready_before_aw", WREADY, 1'b0);
    check("aw_ready", AWREADY, 1'b1);
    AWADDR  = a;
    AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA   = d;
    WSTRB   = s;
    WVALID  = 1'b1;
    check("w_ready", WREADY, 1'b1);
    @(negedge ACLK);
    WVALID  = 1'b0;
    check("bvalid", BVALID, 1'b1);
    b0 = BRESP;
    for (int c = 0; c < hold; c++) begin
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 1'b1);
      check("bresp_hold", BRESP, b0);
      check("awready_hold", AWREADY, 1'b0);
    end
    BREADY = 1'b1;
    got = wq.pop_front();
    check("bresp", BRESP, got.resp);
    @(negedge ACLK);
    check("bvalid_clear", BVALID, 1'b0);
    check_state();
  endtask

  // Enters and leaves on a falling edge; hold = cycles RREADY is kept low.
  task automatic axi_read(input logic [31:0] a, input int hold);
    rsp_t        e, got;
    logic [31:0] d0;
    logic [1:0]  r0;
    e.data = (a < 32'h40) ? mdl[a[5:2]] : 32'h0;
    e.resp = (a < 32'h40) ? 2'b00 : 2'b10;
    rq.push_back(e);
    RREADY  = (hold == 0);
    check("ar_ready", ARREADY, 1'b1);
    ARADDR  = a;
    ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("rvalid", RVALID, 1'b1);
    d0 = RDATA;
    r0 = RRESP;
    for (int c = 0; c < hold; c++) begin
      @(negedge ACLK);
      check("rvalid_hold", RVALID, 1'b1);
      check("rdata_hold", RDATA, d0);
      check("rresp_hold", RRESP, r0);
      check("arready_hold", ARREADY, 1'b0);
    end
    RREADY = 1'b1;
    got = rq.pop_front();
    check("rdata", RDATA, got.data);
    check("rresp", RRESP, got.resp);
    @(negedge ACLK);
    check("rvalid_clear", RVALID, 1'b0);
  endtask

  initial begin
    rsp_t got;
    for (int i = 0; i < NR; i++) begin
      mdl[i]       = '0;
      exp_pulse[i] = 0;
    end

    // reset state
    repeat (2) @(negedge ACLK);
    check("rst_awready", AWREADY, 1'b1);
    check("rst_arready", ARREADY, 1'b1);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_rresp", RRESP, 2'b00);
    check("rst_rdata", RDATA, 32'h0);
    check_state();
    ARESETn = 1'b1;
    @(negedge ACLK);

    // full-strobe write and read back
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
    axi_read(32'h08, 0);

    // partial strobe
    axi_write(32'h08, 32'h11223344, 4'b0101, 0);
    axi_read(32'h08, 0);

    // out of range and unaligned
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0);
    axi_read(32'h40, 0);
    axi_read(32'h0B, 0);

    // backpressure on both response channels
    axi_write(32'h0C, 32'h12345678, 4'hF, 5);
    axi_read(32'h0C, 5);

    // AR accepted on the same edge as a W commit to the same register
    wq.push_back('{resp: 2'b00, data: 32'h0});
    rq.push_back('{resp: 2'b00, data: mdl[1]});
    mdl[1] = 32'hA5A5A5A5;
    exp_pulse[1]++;
    AWADDR  = 32'h04;
    AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA   = 32'hA5A5A5A5;
    WSTRB   = 4'hF;
    WVALID  = 1'b1;
    ARADDR  = 32'h04;
    ARVALID = 1'b1;
    check("coll_wready", WREADY, 1'b1);
    check("coll_arready", ARREADY, 1'b1);
    @(negedge ACLK);
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    check("coll_bvalid", BVALID, 1'b1);
    check("coll_rvalid", RVALID, 1'b1);
    got = wq.pop_front();
    check("coll_bresp", BRESP, got.resp);
    got = rq.pop_front();
    check("coll_rdata", RDATA, got.data);
    check("coll_rresp", RRESP, got.resp);
    @(negedge ACLK);
    check("coll_bvalid_clear", BVALID, 1'b0);
    check("coll_rvalid_clear", RVALID, 1'b0);
    check_state();
    axi_read(32'h04, 0);

    // reset in the middle of a stalled read
    RREADY  = 1'b0;
    ARADDR  = 32'h08;
    ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("pre_rst_rvalid", RVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    check("midrst_rvalid", RVALID, 1'b0);
    check("midrst_awready", AWREADY, 1'b1);
    check("midrst_arready", ARREADY, 1'b1);
    check("midrst_rdata", RDATA, 32'h0);
    check("midrst_regs_o", regs_o, '0);
    check("midrst_regs_hi", regs_o[NR*32-1:64], '0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    RREADY  = 1'b1;
    @(negedge ACLK);
    check_state();
    axi_read(32'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
